// File: rtl/spi_reg_pkg.sv
// Shared types and sizing helpers for the SPI register-file slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CMD_W      = 1 + ADDR_W_DEF;
  localparam int unsigned FRAME_W    = CMD_W + DATA_W_DEF;
  localparam int unsigned RW_BIT     = ADDR_W_DEF;

  function automatic int unsigned cmd_w(input int unsigned addr_w);
    return 1 + addr_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned addr_w, input int unsigned data_w);
    return $clog2(1 + addr_w + data_w) + 1;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI select/data-in pins plus the access strobes reported to the host model.
interface spi_reg_slave_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              wr_strb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_strb;
    logic [ADDR_W-1:0] rd_addr;

    modport slave (
        input  ss_n, mosi,
        output wr_strb, wr_addr, wr_data, rd_strb, rd_addr
    );

    modport master (
        output ss_n, mosi,
        input  wr_strb, wr_addr, wr_data, rd_strb, rd_addr
    );
endinterface

// File: rtl/spi_slv_frame.sv
// SPI mode-0 framing: bit counter, rx/tx shifters and frame FSM.
// Define SPI_REG_SLAVE_BURST_EN for auto-incrementing multi-word frames.
module spi_slv_frame
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_word,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic              load,
    output logic              word_done,
    output logic [DATA_W-1:0] rx_word,
    output logic              miso_bit
);
    localparam int unsigned CMD_BITS = cmd_w(ADDR_W);
    localparam int unsigned CNT_BITS = cnt_w(ADDR_W, DATA_W);
    localparam int unsigned RX_BITS  = max_w(CMD_BITS, DATA_W) - 1;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [RX_BITS-1:0]  rx_q, rx_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                load_q, load_d;
    logic [CMD_BITS-1:0] cmd_word;
    logic [DATA_W-1:0]   tx_q;
    logic                tx_en_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = {rx_q[RX_BITS-2:0], mosi};
        rw_d      = rw_q;
        addr_d    = addr_q;
        load_d    = 1'b0;
        word_done = 1'b0;
        cmd_word  = {rx_q[CMD_BITS-2:0], mosi};
        rx_word   = {rx_q[DATA_W-2:0], mosi};
        unique case (state_q)
            IDLE: begin
                state_d = CMD;
                cnt_d   = CNT_BITS'(1);
            end
            CMD: begin
                if (cnt_q == CNT_BITS'(CMD_BITS - 1)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    rw_d    = cmd_word[ADDR_W];
                    addr_d  = cmd_word[ADDR_W-1:0];
                    load_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_BITS'(DATA_W - 1)) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
`ifdef SPI_REG_SLAVE_BURST_EN
                    addr_d    = addr_q + ADDR_W'(1);
                    load_d    = 1'b1;
`else
                    state_d   = DONE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            DONE: rx_d = rx_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge rst_n or posedge ss_n) begin
        if (!rst_n || ss_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
        end
    end

    // Falling-edge half: load/shift so each bit is stable before the master samples it.
    always_ff @(negedge SCLK or negedge rst_n or posedge ss_n) begin
        if (!rst_n || ss_n) begin
            tx_q    <= '0;
            tx_en_q <= 1'b0;
        end else begin
            tx_en_q <= (state_q == DATA);
            if (load_q) begin
                tx_q <= tx_word;
            end else if (state_q == DATA) begin
                tx_q <= tx_q << 1;
            end
        end
    end

    assign rw       = rw_q;
    assign addr     = addr_q;
    assign load     = load_q;
    assign miso_bit = tx_en_q & tx_q[DATA_W-1];
endmodule

// File: rtl/spi_reg_slave.sv
// SPI register-file slave: R/W register array, live read-only window, access strobes.
// Optional burst mode via SPI_REG_SLAVE_BURST_EN (handled in spi_slv_frame).
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned NUM_RO   = 4,
    parameter int unsigned RO_BASE  = 'h22,
    parameter int unsigned WR_RESP  = 'hA5
) (
    input  logic                     SCLK,
    input  logic                     rst_n,
    spi_reg_slave_if.slave           bus,
    input  logic [NUM_RO*DATA_W-1:0] ro_data,
    output wire                      miso
);
    logic              ss_n;
    logic              rw, load, word_done, miso_bit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rx_word, tx_word, rd_word, ro_word;
    logic              in_ro, in_rw, we;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_strb_q, rd_strb_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign ss_n = bus.ss_n;

    spi_slv_frame #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_frame (
        .SCLK     (SCLK),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (bus.mosi),
        .tx_word  (tx_word),
        .rw       (rw),
        .addr     (addr),
        .load     (load),
        .word_done(word_done),
        .rx_word  (rx_word),
        .miso_bit (miso_bit)
    );

    // The RO window shadows any R/W register at the same address.
    always_comb begin
        in_ro   = 1'b0;
        ro_word = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (32'(addr) == RO_BASE + i) begin
                in_ro   = 1'b1;
                ro_word = ro_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_rw   = 32'(addr) < NUM_REGS;
    assign rd_word = in_ro ? ro_word : (in_rw ? regs[addr] : '0);
    assign tx_word = rw ? rd_word : DATA_W'(WR_RESP);
    assign we      = word_done & ~rw & in_rw & ~in_ro;

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[addr] <= rx_word;
        end
    end

    always_ff @(posedge SCLK or negedge rst_n or posedge ss_n) begin
        if (!rst_n || ss_n) wr_strb_q <= 1'b0;
        else                wr_strb_q <= we;
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (we) begin
            wr_addr_q <= addr;
            wr_data_q <= rx_word;
        end
    end

    always_ff @(negedge SCLK or negedge rst_n or posedge ss_n) begin
        if (!rst_n || ss_n) rd_strb_q <= 1'b0;
        else                rd_strb_q <= load & rw;
    end

    always_ff @(negedge SCLK or negedge rst_n) begin
        if (!rst_n)         rd_addr_q <= '0;
        else if (load & rw) rd_addr_q <= addr;
    end

    assign bus.wr_strb = wr_strb_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_strb = rd_strb_q;
    assign bus.rd_addr = rd_addr_q;
    assign miso        = ss_n ? 1'bz : miso_bit;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: writes, reads, RO window, aborts, reset, burst.
module tb_spi_reg_slave;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_RO = 4;

    logic                     SCLK = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_RO*DATA_W-1:0] ro_data;
    wire                      miso;

    spi_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_reg_slave #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(128),
        .NUM_RO  (NUM_RO),
        .RO_BASE ('h22),
        .WR_RESP ('hA5)
    ) dut (
        .SCLK   (SCLK),
        .rst_n  (rst_n),
        .bus    (bus),
        .ro_data(ro_data),
        .miso   (miso)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] miso_sh;
    int          wr_cnt, rd_cnt;
    logic [6:0]  wr_addr_seen, rd_addr_seen;
    logic [7:0]  wr_data_seen;

    task automatic frame(input logic [31:0] word, input int nbits, input bit end_frame);
        miso_sh = '0;
        wr_cnt  = 0;
        rd_cnt  = 0;
        bus.ss_n = 1'b0;
        #5;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = word[i];
            #4;
            miso_sh = {miso_sh[30:0], miso};
            SCLK = 1'b1;
            #1;
            if (bus.wr_strb === 1'b1) begin
                wr_cnt++;
                wr_addr_seen = bus.wr_addr;
                wr_data_seen = bus.wr_data;
            end
            #4;
            SCLK = 1'b0;
            #1;
            if (bus.rd_strb === 1'b1) begin
                rd_cnt++;
                rd_addr_seen = bus.rd_addr;
            end
        end
        if (end_frame) begin
            #4;
            bus.ss_n = 1'b1;
            #10;
        end
    endtask

    task automatic test_reset();
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        rst_n    = 1'b0;
        ro_data  = {8'h3C, 8'h9E, 8'h17, 8'hC2};
        #20;
        n_checks++; if (bus.wr_strb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strb got %b want 0", bus.wr_strb); end
        n_checks++; if (bus.rd_strb !== 1'b0) begin n_fail++; $display("FAIL reset_rd_strb got %b want 0", bus.rd_strb); end
        n_checks++; if (bus.wr_addr !== 7'h00) begin n_fail++; $display("FAIL reset_wr_addr got %h want 00", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
        n_checks++; if (bus.rd_addr !== 7'h00) begin n_fail++; $display("FAIL reset_rd_addr got %h want 00", bus.rd_addr); end
        rst_n = 1'b1;
        #10;
    endtask

    task automatic test_write();
        frame(32'h0D02, 16, 1'b0);
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wr_strb_count got %0d want 1", wr_cnt); end
        n_checks++; if (wr_addr_seen !== 7'h0D) begin n_fail++; $display("FAIL wr_addr got %h want 0d", wr_addr_seen); end
        n_checks++; if (wr_data_seen !== 8'h02) begin n_fail++; $display("FAIL wr_data got %h want 02", wr_data_seen); end
        n_checks++; if (miso_sh[7:0] !== 8'hA5) begin n_fail++; $display("FAIL wr_resp got %h want a5", miso_sh[7:0]); end
        // One extra clock in DONE: strobe must be gone and miso held low.
        #4; SCLK = 1'b1; #1;
        n_checks++; if (bus.wr_strb !== 1'b0) begin n_fail++; $display("FAIL wr_strb_width got %b want 0", bus.wr_strb); end
        #4; SCLK = 1'b0; #1;
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL done_miso got %b want 0", miso); end
        #4; bus.ss_n = 1'b1; #10;
    endtask

    task automatic test_read();
        frame(32'h8D00, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h02) begin n_fail++; $display("FAIL rd_reg_data got %h want 02", miso_sh[7:0]); end
        n_checks++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL rd_strb_count got %0d want 1", rd_cnt); end
        n_checks++; if (rd_addr_seen !== 7'h0D) begin n_fail++; $display("FAIL rd_addr got %h want 0d", rd_addr_seen); end
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rd_no_wr got %0d want 0", wr_cnt); end
        frame(32'hA200, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'hC2) begin n_fail++; $display("FAIL rd_ro_ch0 got %h want c2", miso_sh[7:0]); end
        n_checks++; if (rd_addr_seen !== 7'h22) begin n_fail++; $display("FAIL rd_ro_addr got %h want 22", rd_addr_seen); end
    endtask

    task automatic test_ro_window();
        frame(32'h2255, 16, 1'b1);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL ro_write_dropped got %0d want 0", wr_cnt); end
        frame(32'hA200, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'hC2) begin n_fail++; $display("FAIL ro_not_overwritten got %h want c2", miso_sh[7:0]); end
        frame(32'hA500, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h3C) begin n_fail++; $display("FAIL ro_ch3 got %h want 3c", miso_sh[7:0]); end
        // 0x26 is just past the window and must behave as a normal register.
        frame(32'h2677, 16, 1'b1);
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL past_window_wr got %0d want 1", wr_cnt); end
        frame(32'hA600, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h77) begin n_fail++; $display("FAIL past_window_rd got %h want 77", miso_sh[7:0]); end
    endtask

    task automatic test_abort();
        frame(32'h113, 12, 1'b1);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL abort_no_strb got %0d want 0", wr_cnt); end
        frame(32'h9100, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h00) begin n_fail++; $display("FAIL abort_reg_kept got %h want 00", miso_sh[7:0]); end
        frame(32'h1133, 16, 1'b1);
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL after_abort_wr got %0d want 1", wr_cnt); end
        frame(32'h9100, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h33) begin n_fail++; $display("FAIL after_abort_rd got %h want 33", miso_sh[7:0]); end
    endtask

    task automatic test_reset_mid();
        frame(32'h8D00 >> 6, 10, 1'b0);
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.rd_strb !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_strb got %b want 0", bus.rd_strb); end
        n_checks++; if (bus.wr_strb !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_strb got %b want 0", bus.wr_strb); end
        n_checks++; if (bus.rd_addr !== 7'h00) begin n_fail++; $display("FAIL mid_rst_rd_addr got %h want 00", bus.rd_addr); end
        bus.ss_n = 1'b1;
        #10;
        rst_n = 1'b1;
        #10;
        frame(32'h8D00, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h00) begin n_fail++; $display("FAIL mid_rst_reg_cleared got %h want 00", miso_sh[7:0]); end
        n_checks++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL mid_rst_rd_strb_after got %0d want 1", rd_cnt); end
    endtask

    task automatic test_burst();
        frame(32'h7EAABB, 24, 1'b1);
`ifdef SPI_REG_SLAVE_BURST_EN
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL burst_wr_count got %0d want 2", wr_cnt); end
        n_checks++; if (wr_addr_seen !== 7'h7F) begin n_fail++; $display("FAIL burst_wr_addr got %h want 7f", wr_addr_seen); end
        n_checks++; if (wr_data_seen !== 8'hBB) begin n_fail++; $display("FAIL burst_wr_data got %h want bb", wr_data_seen); end
`else
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL single_wr_count got %0d want 1", wr_cnt); end
        n_checks++; if (wr_addr_seen !== 7'h7E) begin n_fail++; $display("FAIL single_wr_addr got %h want 7e", wr_addr_seen); end
        n_checks++; if (wr_data_seen !== 8'hAA) begin n_fail++; $display("FAIL single_wr_data got %h want aa", wr_data_seen); end
`endif
        frame(32'hFE0000, 24, 1'b1);
`ifdef SPI_REG_SLAVE_BURST_EN
        n_checks++; if (miso_sh[15:0] !== 16'hAABB) begin n_fail++; $display("FAIL burst_rd_data got %h want aabb", miso_sh[15:0]); end
        n_checks++; if (rd_cnt !== 2) begin n_fail++; $display("FAIL burst_rd_count got %0d want 2", rd_cnt); end
        n_checks++; if (rd_addr_seen !== 7'h7F) begin n_fail++; $display("FAIL burst_rd_addr got %h want 7f", rd_addr_seen); end
`else
        n_checks++; if (miso_sh[15:0] !== 16'hAA00) begin n_fail++; $display("FAIL single_rd_data got %h want aa00", miso_sh[15:0]); end
        n_checks++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL single_rd_count got %0d want 1", rd_cnt); end
        frame(32'hFF00, 16, 1'b1);
        n_checks++; if (miso_sh[7:0] !== 8'h00) begin n_fail++; $display("FAIL single_7f_untouched got %h want 00", miso_sh[7:0]); end
`endif
    endtask

    initial begin
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_ro_window();
        test_abort();
        test_reset_mid();
        test_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
